// File: rtl/frame_decoder.sv
// frame_decoder: captures 12-bit words from the receiver shift register, checks
// header / even parity / address, and queues accepted {addr,data} entries in a
// small FIFO drained through a valid/ready handshake. Keeps saturating good and
// error counters and a sticky overflow flag.
module frame_decoder #(
  parameter logic [3:0]  MY_ADDR = 4'h3,
  parameter logic [2:0]  HEADER  = 3'b101,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] word_in,
  input  logic        word_load,
  output logic [3:0]  out_data,
  output logic [3:0]  out_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  good_cnt,
  output logic [7:0]  err_cnt,
  output logic        overflow
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // stage 1 capture
  logic        cap_valid;
  logic [11:0] cap_word;

  // classification of the captured word
  logic hdr_ok, par_ok, addr_ok, is_err, is_good;

  // stage 2 registered classification result
  logic       s2_good, s2_err;
  logic [7:0] s2_entry;

  // FIFO state
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   count, count_next;
  logic          pop, push, drop;
  logic [7:0]    head_next;

  // Latch the parallel word on the dump strobe; word_in is ignored otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_valid <= 1'b0;
      cap_word  <= '0;
    end else begin
      cap_valid <= word_load;
      if (word_load) cap_word <= word_in;
    end
  end

  // Classify: header or parity failure is an error; otherwise address decides accept/skip.
  always_comb begin
    hdr_ok  = (cap_word[11:9] == HEADER);
    par_ok  = ~(^cap_word);
    addr_ok = (cap_word[8:5] == MY_ADDR) || (cap_word[8:5] == 4'hF);
    is_err  = cap_valid && !(hdr_ok && par_ok);
    is_good = cap_valid && hdr_ok && par_ok && addr_ok;
  end

  // Register the classification so the FIFO push lands one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_good  <= 1'b0;
      s2_err   <= 1'b0;
      s2_entry <= '0;
    end else begin
      s2_good  <= is_good;
      s2_err   <= is_err;
      s2_entry <= cap_word[8:1];
    end
  end

  // FIFO control: a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    pop        = out_valid && out_ready;
    push       = s2_good && ((count < DEPTH_C) || pop);
    drop       = s2_good && !push;
    rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_next = count;
    if (push && !pop) count_next = count + 1'b1;
    if (pop && !push) count_next = count - 1'b1;
    // Head register is preloaded with whatever entry will sit at rd_next after this
    // edge; when that slot is the one being written now, take the incoming entry.
    head_next  = (push && (wr_ptr == rd_next)) ? s2_entry : mem[rd_next];
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s2_entry;
  end

  // FIFO pointers, occupancy and registered head contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      count  <= count_next;
      if (count_next != '0) {out_addr, out_data} <= head_next;
    end
  end

  // Saturating counters and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      good_cnt <= '0;
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (s2_good && (good_cnt != 8'hFF)) good_cnt <= good_cnt + 1'b1;
      if (s2_err  && (err_cnt  != 8'hFF)) err_cnt  <= err_cnt + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  assign out_valid = (count != '0);

endmodule
